fnn_act_collect: RTL and testbench

Downstream stage of the 62-input MAC. Accepts one 21-bit sign-magnitude accumulator result per neuron over a valid/ready stream. Applies ReLU, right-shift requantization and saturation to produce 8-bit sign-magnitude activations. Packs them into one activation vector for the next layer's MAC, and tracks the argmax over the raw accumulators for the final classification layer.

---
 rtl/fnn_pkg.sv | 25 ++
 rtl/fnn_act_requant.sv | 32 +++
 rtl/fnn_act_collect.sv | 118 +++++++++++
 tb/tb_fnn_act_collect.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fnn_pkg.sv
// rtl/fnn_pkg.sv - shared widths, state enum and sign-magnitude helper for the FNN datapath
// Contents:
//   ACT_W      activation byte width (sign-magnitude, 8 bits)
//   ACC_W      MAC accumulator width (sign-magnitude, 21 bits)
//   state_t    collector FSM states
//   sm_to_tc   sign-magnitude to two's complement; negative zero maps to 0
package fnn_pkg;

  localparam int ACT_W = 8;
  localparam int ACC_W = 21;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [ACC_W-1:0] sm);
    logic signed [ACC_W-1:0] mag;
    // Zero-extended magnitude always fits as a positive value, so negation
    // cannot overflow, and -0 naturally yields 0.
    mag = $signed({1'b0, sm[ACC_W-2:0]});
    return sm[ACC_W-1] ? -mag : mag;
  endfunction

endpackage

// File: rtl/fnn_act_requant.sv
// rtl/fnn_act_requant.sv - ReLU, right-shift requantization and saturation to one activation byte
// Ports:
//   acc  in   ACC_W  sign-magnitude accumulator (MSB = sign)
//   act  out  ACT_W  sign-magnitude activation; sign bit is always 0
// Parameter:
//   SHIFT  right-shift applied to the magnitude before saturation
module fnn_act_requant
  import fnn_pkg::*;
#(
  parameter int SHIFT = 6
) (
  input  logic [ACC_W-1:0] acc,
  output logic [ACT_W-1:0] act
);

  logic [ACC_W-2:0] m;

  assign m = acc[ACC_W-2:0] >> SHIFT;

  always_comb begin
    act = '0;
    // Any negative input, including negative zero, is clipped to 0 by ReLU.
    if (!acc[ACC_W-1]) begin
      if (m > (ACC_W-1)'(127)) begin
        act = 8'h7F;
      end else begin
        act = {1'b0, m[6:0]};
      end
    end
  end

endmodule

// File: rtl/fnn_act_collect.sv
// rtl/fnn_act_collect.sv - collects requantized neuron results into one activation vector with argmax
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     accumulator beat valid
//   in_ready     collector accepts a beat (COLLECT state)
//   in_data      21-bit sign-magnitude accumulator
//   out_valid    complete vector available (HOLD state)
//   out_ready    consumer takes the vector
//   out_act      NUM_NEURONS activation bytes, neuron i at bits 8i+7:8i
//   out_argmax   index of the largest signed accumulator of the vector
module fnn_act_collect
  import fnn_pkg::*;
#(
  parameter int NUM_NEURONS = 62,
  parameter int SHIFT       = 6,
  parameter int IDX_W       = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ACC_W-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_NEURONS*ACT_W-1:0] out_act,
  output logic [IDX_W-1:0]             out_argmax
);

  state_t                         state_q;
  state_t                         state_n;
  logic [IDX_W-1:0]               cnt_q;
  logic [NUM_NEURONS*ACT_W-1:0]   act_q;
  logic signed [ACC_W-1:0]        max_val_q;
  logic [IDX_W-1:0]               max_idx_q;
  logic signed [ACC_W-1:0]        cur_val;
  logic [ACT_W-1:0]               act_byte;
  logic                           accept;
  logic                           release_vec;
  logic                           last_beat;

  fnn_act_requant #(
    .SHIFT (SHIFT)
  ) u_requant (
    .acc (in_data),
    .act (act_byte)
  );

  // Handshake strobes are decoded from registered state only, so neither
  // in_valid nor out_ready reaches an output combinationally.
  assign in_ready    = (state_q == COLLECT);
  assign out_valid   = (state_q == HOLD);
  assign accept      = in_valid && in_ready;
  assign release_vec = out_valid && out_ready;
  assign last_beat   = (cnt_q == IDX_W'(NUM_NEURONS - 1));
  assign cur_val     = sm_to_tc(in_data);

  assign out_act     = act_q;
  assign out_argmax  = max_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      COLLECT: if (accept && last_beat) state_n = HOLD;
      HOLD:    if (release_vec)         state_n = COLLECT;
      default:                          state_n = COLLECT;
    endcase
  end

  // The counter parks on the last slot while the vector is held and is
  // cleared by the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (release_vec) begin
      cnt_q <= '0;
    end else if (accept && !last_beat) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Slot 0 always loads the tracker; later slots replace it only when
  // strictly larger, so ties keep the lowest index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (release_vec) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (accept && ((cnt_q == '0) || (cur_val > max_val_q))) begin
      max_val_q <= cur_val;
      max_idx_q <= cnt_q;
    end
  end

  // The packing register is not cleared between vectors; each slot is
  // simply overwritten as its new beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (accept && (cnt_q == IDX_W'(i))) begin
          act_q[i*ACT_W +: ACT_W] <= act_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_fnn_act_collect.sv
// tb/tb_fnn_act_collect.sv - randomized and directed self-checking bench for fnn_act_collect
module tb_fnn_act_collect;

  localparam int N  = 62;
  localparam int SH = 6;
  localparam int IW = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [20:0]    in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N*8-1:0] out_act;
  logic [IW-1:0]  out_argmax;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: activation bytes, signed values of the
  // current vector, and whether the vector is complete.
  logic [7:0] m_act [N];
  int         m_val [$];
  bit         m_full = 1'b0;

  fnn_act_collect #(
    .NUM_NEURONS (N),
    .SHIFT       (SH),
    .IDX_W       (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_act    (out_act),
    .out_argmax (out_argmax)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N*8-1:0] obs, input logic [N*8-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rq(input logic [20:0] d);
    int m;
    if (d[20]) return 8'h00;
    m = int'(d[19:0]) / (1 << SH);
    return (m > 127) ? 8'd127 : 8'(m);
  endfunction

  function automatic int tc(input logic [20:0] d);
    return d[20] ? -int'(d[19:0]) : int'(d[19:0]);
  endfunction

  function automatic logic [N*8-1:0] exp_vec();
    logic [N*8-1:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = m_act[i];
    return v;
  endfunction

  function automatic logic [N*8-1:0] exp_arg();
    int best = 0;
    for (int i = 1; i < m_val.size(); i++)
      if (m_val[i] > m_val[best]) best = i;
    return (N*8)'(best);
  endfunction

  function automatic logic [20:0] rnd_beat();
    logic [19:0] mag;
    if ($urandom_range(0, 3) == 0) mag = 20'($urandom());
    else mag = 20'($urandom_range(0, 9000));
    return {1'($urandom_range(0, 1)), mag};
  endfunction

  task automatic check_all();
    check("in_ready",   in_ready,   !m_full);
    check("out_valid",  out_valid,  m_full);
    check("out_act",    out_act,    exp_vec());
    check("out_argmax", out_argmax, exp_arg());
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_act[i] = 8'h00;
    m_val.delete();
    m_full = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, advance one rising edge,
  // update the model, then check at the next falling edge.
  task automatic step(input logic v, input logic [20:0] d, input logic r);
    bit acc, hs;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    acc = v && !m_full;
    hs  = m_full && r;
    @(posedge clk);
    if (acc) begin
      m_act[m_val.size()] = rq(d);
      m_val.push_back(tc(d));
      if (m_val.size() == N) m_full = 1'b1;
    end
    if (hs) begin
      m_full = 1'b0;
      m_val.delete();
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic send_beat(input logic [20:0] d);
    while (m_full) step(1'b0, '0, 1'b1);
    step(1'b1, d, 1'b0);
  endtask

  task automatic drain();
    while (m_full) step(1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    #2;
    check("rst_async_ready", in_ready, 1'b1);
    check("rst_async_valid", out_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int vecs;
    int cycles;
    logic [N*8-1:0] snap;
    logic v, r;

    model_clear();
    @(negedge clk);
    do_reset();

    // Single value requantization checks
    send_beat({1'b0, 20'd6400});
    check("byte0_6400", out_act[7:0], 8'h64);
    send_beat({1'b0, 20'd100000});
    check("byte1_sat", out_act[15:8], 8'h7F);
    send_beat({1'b1, 20'd500});
    check("byte2_neg", out_act[23:16], 8'h00);
    send_beat({1'b1, 20'd0});
    check("byte3_negzero", out_act[31:24], 8'h00);
    for (int i = 4; i < N; i++) send_beat(rnd_beat());
    drain();

    // Ramp vector: byte i = i, argmax at the last slot
    for (int i = 0; i < N; i++) send_beat({1'b0, 20'(i << SH)});
    check("ramp_valid", out_valid, 1'b1);
    check("ramp_argmax", out_argmax, 6'd61);
    check("ramp_byte61", out_act[61*8 +: 8], 8'd61);
    drain();

    // Negative zero ties positive zero; lower index wins
    for (int i = 0; i < N; i++) begin
      if (i == 17)      send_beat({1'b1, 20'd0});
      else if (i == 40) send_beat({1'b0, 20'd0});
      else              send_beat({1'b1, 20'($urandom_range(1, 500000))});
    end
    check("tie_argmax", out_argmax, 6'd17);
    drain();

    for (int i = 0; i < N; i++) send_beat({1'b1, 20'd5});
    check("alleq_argmax", out_argmax, 6'd0);
    drain();

    // Backpressure in HOLD with in_valid asserted
    for (int i = 0; i < N; i++) send_beat(rnd_beat());
    snap = out_act;
    for (int i = 0; i < 10; i++) step(1'b1, rnd_beat(), 1'b0);
    check("bp_stable", out_act, snap);
    check("bp_ready", in_ready, 1'b0);
    step(1'b0, '0, 1'b1);
    send_beat({1'b0, 20'(3 << SH)});
    check("bp_slot0", out_act[7:0], 8'd3);
    for (int i = 1; i < N; i++) send_beat(rnd_beat());
    drain();

    // Random valid gaps and random out_ready
    vecs = 0;
    cycles = 0;
    while (vecs < 100 && cycles < 40000) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (m_full && r) vecs++;
      step(v, rnd_beat(), r);
      cycles++;
    end
    check("rand_vectors", 32'(vecs), 32'd100);

    // Reset in the middle of a vector
    do_reset();
    for (int i = 0; i < 30; i++) send_beat(rnd_beat());
    do_reset();
    check("rst_act_zero", out_act, '0);
    for (int i = 0; i < N; i++) send_beat(rnd_beat());
    check("post_rst_valid", out_valid, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
